temporal_accumulator_ctrl: RTL and testbench

Sequencer for the temporal accumulator in the HDC encoder pipeline.
- Accepts bound n-gram hypervectors from the n-gram binder over a valid/ready handshake.
- Drives the accumulator's first-vector and enable controls over a window of `WINDOW_LEN` n-grams.
- Presents the thresholded query hypervector to the associative-memory search stage over a second valid/ready handshake.
- Sits between the binder and the AM search. It carries control only; hypervector data goes straight from the binder to the accumulator and then to the AM.

---
 rtl/temporal_accumulator_ctrl_pkg.sv | 20 ++
 rtl/temporal_accumulator_ctrl.sv | 115 +++++++++++
 tb/tb_temporal_accumulator_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/temporal_accumulator_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the temporal accumulator sequencer.
package temporal_accumulator_ctrl_pkg;

  // n-grams folded into one query hypervector by default
  localparam int unsigned NGRAM_ACCUM_CYCLE = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/temporal_accumulator_ctrl.sv
// Window sequencer between the n-gram binder and the AM search: drives the
// accumulator first/enable controls and hands each finished window downstream.
module temporal_accumulator_ctrl
  import temporal_accumulator_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = NGRAM_ACCUM_CYCLE,
  parameter int unsigned CNT_W      = ceil_log2(NGRAM_ACCUM_CYCLE) + 1,
  parameter int unsigned WCNT_W     = 16
) (
  input  logic              Clk_CI,
  input  logic              Reset_RI,
  input  logic              Clear_SI,
  input  logic              NGramValid_SI,
  output logic              NGramReady_SO,
  output logic              FirstHypervector_SO,
  output logic              AccumEnable_SO,
  output logic              ResultValid_SO,
  input  logic              ResultReady_SI,
  output logic [CNT_W-1:0]  InWindowCount_DO,
  output logic [WCNT_W-1:0] WindowCount_DO,
  output logic              Busy_SO
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WINDOW_LEN);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               ngram_ready;
  logic               accept;

  // State register
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    if (Clear_SI) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_d   = CNT_ONE;
            state_d = (WINDOW_LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              cnt_d   = CNT_FULL;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          // A consumed result may overlap the first n-gram of the next window
          if (ResultReady_SI) begin
            wcnt_d = wcnt_q + WCNT_ONE;
            if (accept) begin
              cnt_d   = CNT_ONE;
              state_d = (WINDOW_LEN == 1) ? DONE : ACCUM;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    ngram_ready = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: ngram_ready = 1'b1;
      DONE:        ngram_ready = ResultReady_SI;
      default:     ngram_ready = 1'b0;
    endcase
    if (Reset_RI || Clear_SI) ngram_ready = 1'b0;

    accept              = NGramValid_SI & ngram_ready;
    NGramReady_SO       = ngram_ready;
    AccumEnable_SO      = accept;
    FirstHypervector_SO = accept & (state_q != ACCUM);
    ResultValid_SO      = (state_q == DONE);
    Busy_SO             = (state_q != IDLE);
    InWindowCount_DO    = cnt_q;
    WindowCount_DO      = wcnt_q;
  end

endmodule

// File: tb/tb_temporal_accumulator_ctrl.sv
// Bench for temporal_accumulator_ctrl: directed window scenarios plus randomized
// traffic checked against a count/pending-result model of the window protocol.
module tb_temporal_accumulator_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v5, rr5, clr5, ready5, first5, en5, valid5, busy5;
  logic [3:0]  icnt5;
  logic [15:0] wcnt5;
  logic        v1, rr1, clr1, ready1, first1, en1, valid1, busy1;
  logic [1:0]  icnt1;
  logic [3:0]  wcnt1;

  int checks = 0;
  int errors = 0;

  // Model: n-grams taken in the open window, whether a finished result is
  // waiting downstream, and the number of results consumed so far.
  int unsigned m_cnt;
  bit          m_pend;
  int unsigned m_wcnt;

  temporal_accumulator_ctrl #(.WINDOW_LEN(5), .CNT_W(4), .WCNT_W(16)) dut5 (
    .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr5),
    .NGramValid_SI(v5), .NGramReady_SO(ready5),
    .FirstHypervector_SO(first5), .AccumEnable_SO(en5),
    .ResultValid_SO(valid5), .ResultReady_SI(rr5),
    .InWindowCount_DO(icnt5), .WindowCount_DO(wcnt5), .Busy_SO(busy5)
  );

  temporal_accumulator_ctrl #(.WINDOW_LEN(1), .CNT_W(2), .WCNT_W(4)) dut1 (
    .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr1),
    .NGramValid_SI(v1), .NGramReady_SO(ready1),
    .FirstHypervector_SO(first1), .AccumEnable_SO(en1),
    .ResultValid_SO(valid1), .ResultReady_SI(rr1),
    .InWindowCount_DO(icnt1), .WindowCount_DO(wcnt1), .Busy_SO(busy1)
  );

  function automatic void model_step(input bit v, input bit rr, input bit clr,
                                     input int unsigned w, input int unsigned wmod);
    bit take;
    take = v && !clr && (!m_pend || rr);
    if (clr) begin
      m_cnt  = 0;
      m_pend = 0;
    end else begin
      if (m_pend && rr) begin
        m_wcnt = (m_wcnt + 1) % wmod;
        m_pend = 0;
        m_cnt  = 0;
      end
      if (take) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == w) m_pend = 1;
      end
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v5 = 0; rr5 = 0; clr5 = 0; v1 = 0; rr1 = 0; clr1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_pend = 0; m_wcnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v5 = 1; rr5 = 1; clr5 = 0; v1 = 1; rr1 = 1; clr1 = 0;
    @(negedge clk);
    #1;
    checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready5); end
    checks++; if (en5 !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", en5); end
    checks++; if (first5 !== 1'b0) begin errors++; $display("FAIL reset_first got %b exp 0", first5); end
    checks++; if (valid5 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy5); end
    checks++; if (icnt5 !== 4'd0) begin errors++; $display("FAIL reset_icnt got %0d exp 0", icnt5); end
    checks++; if (wcnt5 !== 16'd0) begin errors++; $display("FAIL reset_wcnt got %0d exp 0", wcnt5); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready_w1 got %b exp 0", ready1); end
    do_reset();
  endtask

  task automatic test_continuous();
    do_reset();
    v5 = 1; rr5 = 1;
    for (int c = 0; c <= 10; c++) begin
      logic [3:0]  ei;
      logic [15:0] ew;
      ei = (c == 0) ? 4'd0 : 4'((c - 1) % 5 + 1);
      ew = (c > 5) ? 16'd1 : 16'd0;
      #1;
      checks++; if (first5 !== (c % 5 == 0)) begin errors++; $display("FAIL cont_first cyc %0d got %b exp %b", c, first5, (c % 5 == 0)); end
      checks++; if (en5 !== 1'b1) begin errors++; $display("FAIL cont_enable cyc %0d got %b exp 1", c, en5); end
      checks++; if (valid5 !== (c == 5 || c == 10)) begin errors++; $display("FAIL cont_valid cyc %0d got %b exp %b", c, valid5, (c == 5 || c == 10)); end
      checks++; if (icnt5 !== ei) begin errors++; $display("FAIL cont_icnt cyc %0d got %0d exp %0d", c, icnt5, ei); end
      checks++; if (wcnt5 !== ew) begin errors++; $display("FAIL cont_wcnt cyc %0d got %0d exp %0d", c, wcnt5, ew); end
      next_cycle();
    end
    #1;
    checks++; if (wcnt5 !== 16'd2) begin errors++; $display("FAIL cont_wcnt_end got %0d exp 2", wcnt5); end
    checks++; if (icnt5 !== 4'd1) begin errors++; $display("FAIL cont_icnt_end got %0d exp 1", icnt5); end
  endtask

  task automatic test_gaps();
    logic [10:0] vmask;
    int exp_cnt [10] = '{1, 1, 2, 3, 3, 3, 3, 4, 4, 5};
    do_reset();
    vmask = 11'b01010001101;
    rr5 = 1;
    for (int c = 0; c <= 10; c++) begin
      v5 = vmask[c];
      #1;
      checks++; if (en5 !== vmask[c]) begin errors++; $display("FAIL gap_enable cyc %0d got %b exp %b", c, en5, vmask[c]); end
      checks++; if (first5 !== (c == 0)) begin errors++; $display("FAIL gap_first cyc %0d got %b exp %b", c, first5, (c == 0)); end
      checks++; if (valid5 !== (c == 10)) begin errors++; $display("FAIL gap_valid cyc %0d got %b exp %b", c, valid5, (c == 10)); end
      if (c > 0) begin
        checks++; if (icnt5 !== 4'(exp_cnt[c-1])) begin errors++; $display("FAIL gap_icnt cyc %0d got %0d exp %0d", c - 1, icnt5, exp_cnt[c-1]); end
      end
      next_cycle();
    end
    #1;
    checks++; if (wcnt5 !== 16'd1) begin errors++; $display("FAIL gap_wcnt got %0d exp 1", wcnt5); end
  endtask

  task automatic test_stall();
    do_reset();
    v5 = 1; rr5 = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (en5 !== 1'b1) begin errors++; $display("FAIL stall_fill_enable cyc %0d got %b exp 1", c, en5); end
      next_cycle();
    end
    for (int c = 5; c < 9; c++) begin
      #1;
      checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %b exp 0", c, ready5); end
      checks++; if (en5 !== 1'b0) begin errors++; $display("FAIL stall_enable cyc %0d got %b exp 0", c, en5); end
      checks++; if (valid5 !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", c, valid5); end
      checks++; if (icnt5 !== 4'd5) begin errors++; $display("FAIL stall_icnt cyc %0d got %0d exp 5", c, icnt5); end
      next_cycle();
    end
    rr5 = 1;
    #1;
    checks++; if (ready5 !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", ready5); end
    checks++; if (first5 !== 1'b1) begin errors++; $display("FAIL release_first got %b exp 1", first5); end
    checks++; if (en5 !== 1'b1) begin errors++; $display("FAIL release_enable got %b exp 1", en5); end
    checks++; if (valid5 !== 1'b1) begin errors++; $display("FAIL release_valid got %b exp 1", valid5); end
    checks++; if (wcnt5 !== 16'd0) begin errors++; $display("FAIL release_wcnt_pre got %0d exp 0", wcnt5); end
    next_cycle();
    #1;
    checks++; if (wcnt5 !== 16'd1) begin errors++; $display("FAIL release_wcnt got %0d exp 1", wcnt5); end
    checks++; if (icnt5 !== 4'd1) begin errors++; $display("FAIL release_icnt got %0d exp 1", icnt5); end
    checks++; if (valid5 !== 1'b0) begin errors++; $display("FAIL release_valid_after got %b exp 0", valid5); end
  endtask

  task automatic test_clear();
    do_reset();
    v5 = 1; rr5 = 1;
    for (int c = 0; c < 3; c++) next_cycle();
    clr5 = 1;
    #1;
    checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL clear_ready got %b exp 0", ready5); end
    checks++; if (en5 !== 1'b0) begin errors++; $display("FAIL clear_enable got %b exp 0", en5); end
    next_cycle();
    clr5 = 0;
    #1;
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", busy5); end
    checks++; if (icnt5 !== 4'd0) begin errors++; $display("FAIL clear_icnt got %0d exp 0", icnt5); end
    checks++; if (wcnt5 !== 16'd0) begin errors++; $display("FAIL clear_wcnt got %0d exp 0", wcnt5); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) #1;
      checks++; if (first5 !== (c == 0)) begin errors++; $display("FAIL clear_refill_first acc %0d got %b exp %b", c, first5, (c == 0)); end
      checks++; if (en5 !== 1'b1) begin errors++; $display("FAIL clear_refill_enable acc %0d got %b exp 1", c, en5); end
      next_cycle();
    end
    v5 = 0;
    #1;
    checks++; if (valid5 !== 1'b1) begin errors++; $display("FAIL clear_done_valid got %b exp 1", valid5); end
    checks++; if (icnt5 !== 4'd5) begin errors++; $display("FAIL clear_done_icnt got %0d exp 5", icnt5); end
  endtask

  task automatic test_async_reset();
    do_reset();
    v5 = 1; rr5 = 1;
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    checks++; if (icnt5 !== 4'd3) begin errors++; $display("FAIL areset_pre_icnt got %0d exp 3", icnt5); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (icnt5 !== 4'd0) begin errors++; $display("FAIL areset_icnt got %0d exp 0", icnt5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy5); end
    checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL areset_ready got %b exp 0", ready5); end
    checks++; if (en5 !== 1'b0) begin errors++; $display("FAIL areset_enable got %b exp 0", en5); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (first5 !== 1'b1) begin errors++; $display("FAIL areset_first got %b exp 1", first5); end
    next_cycle();
    #1;
    checks++; if (icnt5 !== 4'd1) begin errors++; $display("FAIL areset_icnt_after got %0d exp 1", icnt5); end
  endtask

  task automatic test_window_one();
    bit er, ea;
    do_reset();
    for (int c = 0; c < 120; c++) begin
      v1   = ($urandom_range(0, 9) < 7);
      rr1  = ($urandom_range(0, 9) < 8);
      clr1 = ($urandom_range(0, 29) == 0);
      #1;
      er = !clr1 && (!m_pend || rr1);
      ea = v1 && er;
      checks++; if (ready1 !== er) begin errors++; $display("FAIL w1_ready cyc %0d got %b exp %b", c, ready1, er); end
      checks++; if (first1 !== ea) begin errors++; $display("FAIL w1_first cyc %0d got %b exp %b", c, first1, ea); end
      checks++; if (valid1 !== m_pend) begin errors++; $display("FAIL w1_valid cyc %0d got %b exp %b", c, valid1, m_pend); end
      checks++; if (wcnt1 !== m_wcnt[3:0]) begin errors++; $display("FAIL w1_wcnt cyc %0d got %0d exp %0d", c, wcnt1, m_wcnt); end
      model_step(v1, rr1, clr1, 1, 16);
      next_cycle();
    end
    v1 = 0; rr1 = 0; clr1 = 0;
  endtask

  task automatic test_random();
    bit er, ea;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v5   = ($urandom_range(0, 9) < 7);
      rr5  = ($urandom_range(0, 9) < 6);
      clr5 = ($urandom_range(0, 19) == 0);
      #1;
      er = !clr5 && (!m_pend || rr5);
      ea = v5 && er;
      checks++; if (ready5 !== er) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, ready5, er); end
      checks++; if (en5 !== ea) begin errors++; $display("FAIL rand_enable cyc %0d got %b exp %b", c, en5, ea); end
      checks++; if (first5 !== (ea && (m_cnt == 0 || m_pend))) begin errors++; $display("FAIL rand_first cyc %0d got %b exp %b", c, first5, (ea && (m_cnt == 0 || m_pend))); end
      checks++; if (valid5 !== m_pend) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, valid5, m_pend); end
      checks++; if (busy5 !== (m_pend || m_cnt != 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, busy5, (m_pend || m_cnt != 0)); end
      checks++; if (icnt5 !== m_cnt[3:0]) begin errors++; $display("FAIL rand_icnt cyc %0d got %0d exp %0d", c, icnt5, m_cnt); end
      checks++; if (wcnt5 !== m_wcnt[15:0]) begin errors++; $display("FAIL rand_wcnt cyc %0d got %0d exp %0d", c, wcnt5, m_wcnt); end
      model_step(v5, rr5, clr5, 5, 65536);
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_stall();
    test_clear();
    test_async_reset();
    test_window_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
